instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control sequencer for the 16-bit Hack-style CPU. It fetches instructions from program ROM over a req/ack handshake, holds the fetched word stable for the instruction demultiplexer, and turns the demux's decoded destination and jump fields plus the ALU flags into register load strobes, a data-memory write handshake and the next program counter. It sits between the program ROM, the instruction demux, the ALU and the A/D/M register write ports.

## Interface
- DW, 16, instruction/data width; bit DW-1 is the instruction type (0 = A-instruction, 1 = C-instruction)
- AW, 15, program counter / ROM address width
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- run  in  1  level; 1 = execute, 0 = stop at the next instruction boundary
- rom_req  out  1  ROM read request
- rom_addr  out  AW  ROM address; equals pc
- rom_ack  in  1  ROM read acknowledge; rom_data is valid in the same cycle
- rom_data  in  DW  ROM read data
- instr  out  DW  latched instruction, driven to the demux
- instr_valid  out  1  instr is being decoded or executed (DECODE, EXEC, MEMWR)
- instr_type, cmd_d1, cmd_d2, cmd_d3, cmd_j1, cmd_j2, cmd_j3  in  1 each  decoded fields returned by the demux (all 0 for an A-instruction)
- alu_zr  in  1  ALU result is zero
- alu_ng  in  1  ALU result is negative
- a_val  in  AW  current A register value; used as the jump target
- load_a  out  1  one-cycle A register load strobe
- load_d  out  1  one-cycle D register load strobe
- mem_we  out  1  data-memory write request; held until acknowledged
- mem_ack  in  1  data-memory write acknowledge
- pc  out  AW  program counter
- retired  out  1  one-cycle pulse when an instruction completes

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEMWR.
- IDLE: all strobes are 0. On run=1, go to FETCH.
- FETCH: rom_req=1 and rom_addr=pc. While rom_ack=0, stay in FETCH. On rom_ack=1, latch rom_data into instr and go to DECODE. rom_ack is ignored in every other state.
- DECODE: instr_valid=1. This cycle is reserved for the demux/ALU combinational path to settle. No strobes. Always go to EXEC.
- EXEC: all outputs below are combinational in this cycle.
  - load_a = ~instr_type | cmd_d1
  - load_d = cmd_d2
  - jump = cmd_j1&alu_ng | cmd_j2&alu_zr | cmd_j3&~alu_ng&~alu_zr (always 0 for an A-instruction)
  - At the clock edge, pc <= jump ? a_val : pc+1, modulo 2^AW, so pc = 2^AW-1 wraps to 0.
  - The jump target is the A value before this instruction's own A load.
  - If cmd_d3=1, go to MEMWR. Otherwise pulse retired and go to FETCH when run=1, or IDLE when run=0.
- MEMWR: mem_we=1 until mem_ack=1 is sampled. In that cycle, pulse retired and go to FETCH or IDLE per run.
- Sampling run=0 mid-instruction does not abort. The current instruction completes and the sequencer stops in IDLE with pc already advanced.
- Reset (asynchronous, any state): state=IDLE, pc=0, instr=0, and rom_req, instr_valid, load_a, load_d, mem_we, retired all 0. An in-flight ROM or memory transaction is abandoned, and a late ack is ignored.

## Timing
- Instruction latency with zero-wait ack (ack in the first FETCH/MEMWR cycle):
  - 3 cycles without a memory write.
  - 4 cycles with a memory write.
- Each wait cycle on rom_ack or mem_ack adds exactly 1 cycle.
- rom_req rises 1 cycle after IDLE exits, or on the cycle after retired when running back-to-back.
- instr changes only at the FETCH→DECODE edge and is stable through EXEC and MEMWR.
- load_a and load_d are high for exactly one cycle (EXEC). mem_we is high from the first MEMWR cycle through the ack cycle inclusive.
- pc updates only at the EXEC exit edge. It is stable during FETCH, DECODE and MEMWR.
- If rom_ack and a reset deassertion happen in the same cycle, the ack is ignored (the sequencer is in IDLE).

## Test plan
- Reset then run=1, ROM returns 0x0005 with 0-wait ack:
  - rom_req in cycle 1, load_a=1 in cycle 3, load_d=0, mem_we=0.
  - pc 0→1 and retired=1 at the end of cycle 3.
- C-instruction 0xE3F8 (d1 d2 d3 set, no jump), mem_ack after 2 wait cycles:
  - load_a=load_d=1 in EXEC.
  - mem_we high for 3 cycles, retired on the 3rd.
  - pc+1, total 6 cycles.
- Jumps with a_val=0x0123, using jump fields 111 (unconditional), 001 (JGT) and 010 (JEQ):
  - 111: pc=0x0123.
  - 001 with alu_ng=0, alu_zr=0: pc=0x0123.
  - 001 with alu_zr=1: pc+1.
  - 010 with alu_zr=1: pc=0x0123.
- pc=0x7FFF, non-jumping instruction: pc wraps to 0x0000, and rom_addr for the next fetch is 0x0000.
- rom_ack held 0 for 5 cycles in FETCH, then 1:
  - rom_req stays high for 6 cycles and instr is unchanged until the ack.
  - A stray rom_ack pulse during EXEC has no effect.
- run dropped in DECODE, and rst_n pulsed low during MEMWR:
  - For the run drop: the instruction completes, then IDLE with rom_req=0.
  - For the reset: all outputs are 0 immediately and pc=0.
  - After the reset, a late mem_ack is ignored.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit Hack-style CPU.
// Fetches over a ROM req/ack handshake and issues register loads, memory writes and the next pc.
module instr_sequencer #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic          rom_req,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ack,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_type,
  input  logic          cmd_d1,
  input  logic          cmd_d2,
  input  logic          cmd_d3,
  input  logic          cmd_j1,
  input  logic          cmd_j2,
  input  logic          cmd_j3,
  input  logic          alu_zr,
  input  logic          alu_ng,
  input  logic [AW-1:0] a_val,
  output logic          load_a,
  output logic          load_d,
  output logic          mem_we,
  input  logic          mem_ack,
  output logic [AW-1:0] pc,
  output logic          retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEMWR  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] instr_q, instr_d;
  logic          jump_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Strobes are decoded from the state so they drop the instant reset asserts.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    rom_req     = 1'b0;
    instr_valid = 1'b0;
    load_a      = 1'b0;
    load_d      = 1'b0;
    mem_we      = 1'b0;
    retired     = 1'b0;
    jump_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        rom_req = 1'b1;
        if (rom_ack) begin
          instr_d = rom_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        instr_valid = 1'b1;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        load_a      = ~instr_type | cmd_d1;
        load_d      = cmd_d2;
        // a_val is still the pre-load A value here, so it is the correct target.
        jump_c      = instr_type & ((cmd_j1 & alu_ng) | (cmd_j2 & alu_zr) |
                                    (cmd_j3 & ~alu_ng & ~alu_zr));
        pc_d        = jump_c ? a_val : pc_q + AW'(1);
        if (cmd_d3) begin
          state_d = S_MEMWR;
        end else begin
          retired = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_MEMWR: begin
        instr_valid = 1'b1;
        mem_we      = 1'b1;
        if (mem_ack) begin
          retired = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pc       = pc_q;
  assign rom_addr = pc_q;
  assign instr    = instr_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: fetch latency, loads, jumps, pc wrap, waits, run drop, reset.
module tb_instr_sequencer;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 15;

  logic          clk, rst_n, run, rom_req, rom_ack;
  logic [AW-1:0] rom_addr, a_val, pc;
  logic [DW-1:0] rom_data, instr;
  logic          instr_valid, instr_type, cmd_d1, cmd_d2, cmd_d3, cmd_j1, cmd_j2, cmd_j3;
  logic          alu_zr, alu_ng, load_a, load_d, mem_we, mem_ack, retired;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] last_instr;
  logic [AW-1:0] cur_pc;

  instr_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .instr(instr), .instr_valid(instr_valid),
    .instr_type(instr_type), .cmd_d1(cmd_d1), .cmd_d2(cmd_d2), .cmd_d3(cmd_d3),
    .cmd_j1(cmd_j1), .cmd_j2(cmd_j2), .cmd_j3(cmd_j3),
    .alu_zr(alu_zr), .alu_ng(alu_ng), .a_val(a_val),
    .load_a(load_a), .load_d(load_d), .mem_we(mem_we), .mem_ack(mem_ack),
    .pc(pc), .retired(retired)
  );

  // Stand-in for the external instruction demux.
  assign instr_type = instr[15];
  assign cmd_d1     = instr[15] & instr[5];
  assign cmd_d2     = instr[15] & instr[4];
  assign cmd_d3     = instr[15] & instr[3];
  assign cmd_j1     = instr[15] & instr[2];
  assign cmd_j2     = instr[15] & instr[1];
  assign cmd_j3     = instr[15] & instr[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Entered at the start of a FETCH cycle with run=1; leaves at the next FETCH cycle.
  task automatic do_instr(input string tag, input logic [15:0] data, input int rom_wait,
                          input int mem_wait, input logic zr, input logic ng,
                          input logic exp_la, input logic exp_ld, input logic exp_d3,
                          input logic [AW-1:0] exp_pc);
    for (int i = 0; i < rom_wait; i++) begin
      rom_ack = 1'b0;
      #1;
      check({tag, "/req_wait"}, 32'(rom_req), 32'd1);
      check({tag, "/instr_hold"}, 32'(instr), 32'(last_instr));
      cyc();
    end
    rom_ack  = 1'b1;
    rom_data = data;
    #1;
    check({tag, "/req"}, 32'(rom_req), 32'd1);
    check({tag, "/rom_addr"}, 32'(rom_addr), 32'(cur_pc));
    cyc();
    rom_ack  = 1'b0;
    rom_data = 16'hDEAD;
    alu_zr   = zr;
    alu_ng   = ng;
    #1;
    check({tag, "/dec_instr"}, 32'(instr), 32'(data));
    check({tag, "/dec_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "/dec_noload"}, 32'({load_a, load_d, rom_req}), 32'd0);
    cyc();
    rom_ack = 1'b1;
    #1;
    check({tag, "/load_a"}, 32'(load_a), 32'(exp_la));
    check({tag, "/load_d"}, 32'(load_d), 32'(exp_ld));
    check({tag, "/exec_we"}, 32'(mem_we), 32'd0);
    check({tag, "/exec_ret"}, 32'(retired), 32'(!exp_d3));
    check({tag, "/exec_pc"}, 32'(pc), 32'(cur_pc));
    cyc();
    rom_ack = 1'b0;
    if (exp_d3) begin
      for (int i = 0; i <= mem_wait; i++) begin
        mem_ack = (i == mem_wait);
        #1;
        check({tag, "/mem_we"}, 32'(mem_we), 32'd1);
        check({tag, "/mem_ret"}, 32'(retired), 32'(i == mem_wait));
        check({tag, "/mem_pc"}, 32'(pc), 32'(exp_pc));
        cyc();
      end
      mem_ack = 1'b0;
    end
    #1;
    check({tag, "/next_pc"}, 32'(pc), 32'(exp_pc));
    check({tag, "/instr_kept"}, 32'(instr), 32'(data));
    last_instr = data;
    cur_pc     = exp_pc;
  endtask

  initial begin
    rst_n = 1'b1; run = 1'b0; rom_ack = 1'b0; rom_data = '0;
    alu_zr = 1'b0; alu_ng = 1'b0; a_val = '0; mem_ack = 1'b0;
    last_instr = '0; cur_pc = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_strobes", 32'({rom_req, instr_valid, load_a, load_d, mem_we, retired}), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    run   = 1'b1;
    rom_ack = 1'b1;
    #1;
    check("idle_req", 32'(rom_req), 32'd0);
    cyc();
    rom_ack = 1'b0;
    #1;
    check("rom_req_cycle1", 32'(rom_req), 32'd1);

    do_instr("a5",    16'h0005, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0001);
    do_instr("amd",   16'hE3F8, 0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 15'h0002);
    a_val = 15'h0123;
    do_instr("jmp",   16'hE007, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0123);
    do_instr("jgt_t", 16'hE001, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0123);
    do_instr("jgt_f", 16'hE001, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0124);
    do_instr("jeq_t", 16'hE002, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0123);
    a_val = 15'h7FFF;
    do_instr("to_max", 16'hE007, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h7FFF);
    do_instr("wrap",   16'hE000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0000);
    do_instr("romwait", 16'h0042, 5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0001);

    // run dropped while in DECODE: instruction finishes, then IDLE
    rom_ack = 1'b1; rom_data = 16'h0007;
    cyc();
    rom_ack = 1'b0; run = 1'b0;
    #1 check("drop_dec_valid", 32'(instr_valid), 32'd1);
    cyc();
    #1 check("drop_exec_ret", 32'(retired), 32'd1);
    cyc();
    #1;
    check("drop_idle_req", 32'(rom_req), 32'd0);
    check("drop_idle_valid", 32'(instr_valid), 32'd0);
    check("drop_idle_pc", 32'(pc), 32'h0002);
    cyc();
    #1 check("drop_idle_stay", 32'(rom_req), 32'd0);

    // reset pulse during MEMWR, then a late mem_ack
    run = 1'b1;
    cyc();
    rom_ack = 1'b1; rom_data = 16'hE008;
    cyc();
    rom_ack = 1'b0;
    cyc();
    #1 check("mw_exec_ret", 32'(retired), 32'd0);
    cyc();
    #1 check("mw_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mw_rst_strobes", 32'({rom_req, instr_valid, load_a, load_d, mem_we, retired}), 32'd0);
    check("mw_rst_pc", 32'(pc), 32'd0);
    check("mw_rst_instr", 32'(instr), 32'd0);
    cyc();
    run = 1'b0; rst_n = 1'b1; mem_ack = 1'b1;
    #1 check("late_ack0", 32'({mem_we, retired}), 32'd0);
    cyc();
    #1;
    check("late_ack1", 32'({mem_we, retired, rom_req}), 32'd0);
    check("late_ack_pc", 32'(pc), 32'd0);
    mem_ack = 1'b0;
    run = 1'b1;
    cyc();
    #1;
    check("restart_req", 32'(rom_req), 32'd1);
    check("restart_addr", 32'(rom_addr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
